// File: rtl/ysyx_25030085_core_seq.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the NPC core.
// Define YSYX_25030085_SEQ_TIMEOUT_EN to enable the handshake timeout and the ERR state.
module ysyx_25030085_core_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic        ifu_ack,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  input  logic        is_mem,
  input  logic        is_store,
  input  logic        rf_we_dec,
  output logic        lsu_req,
  input  logic        lsu_ack,
  input  logic [31:0] next_pc,
  output logic        rf_we,
  output logic [31:0] pc,
  input  logic [31:0] halt_ret,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        err,
  output logic [63:0] instret
);

  if (TIMEOUT == 0 || TIMEOUT > 1023) begin : g_bad_timeout
    $error("TIMEOUT must lie in 1..1023");
  end

  localparam logic [31:0] Ebreak = 32'h0010_0073;

  typedef enum logic [2:0] {
    StBoot, StFetch, StDecode, StExec, StMem, StWb, StHalt, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] halt_code_q, halt_code_d;
  logic [63:0] instret_q, instret_d;
  logic        timeout;

`ifdef YSYX_25030085_SEQ_TIMEOUT_EN
  localparam logic [9:0] TimeoutCnt = 10'(TIMEOUT);
  logic [9:0] wait_q, wait_d;
  logic       ack;

  assign ack     = (state_q == StFetch && ifu_ack) || (state_q == StMem && lsu_ack);
  assign timeout = (wait_q == TimeoutCnt) && !ack;

  // Staying in a handshake state means no ack arrived; any transition restarts the count.
  always_comb begin
    wait_d = '0;
    if (state_d == state_q && (state_q == StFetch || state_q == StMem)) begin
      wait_d = wait_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      halt_code_q <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      halt_code_q <= halt_code_d;
      instret_q   <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:   state_d = StFetch;
      StFetch: begin
        if (ifu_ack)      state_d = StDecode;
        else if (timeout) state_d = StErr;
      end
      StDecode: state_d = (inst_q == Ebreak) ? StHalt : StExec;
      StExec:   state_d = is_mem ? StMem : StWb;
      StMem: begin
        if (lsu_ack)      state_d = StWb;
        else if (timeout) state_d = StErr;
      end
      StWb:     state_d = StFetch;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    inst_d      = inst_q;
    halt_code_d = halt_code_q;
    instret_d   = instret_q;
    unique case (state_q)
      StFetch: if (ifu_ack) inst_d = ifu_rdata;
      StDecode: begin
        if (inst_q == Ebreak) begin
          halt_code_d = halt_ret;
          instret_d   = instret_q + 64'd1;
        end
      end
      StWb: begin
        pc_d      = next_pc;
        instret_d = instret_q + 64'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ifu_req = (state_q == StFetch);
    lsu_req = (state_q == StMem);
    halt    = (state_q == StHalt);
    rf_we   = (state_q == StWb) && rf_we_dec && !is_store;
  end

`ifdef YSYX_25030085_SEQ_TIMEOUT_EN
  assign err = (state_q == StErr);
`else
  assign err = 1'b0;
`endif

  assign ifu_addr  = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign halt_code = halt_code_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_ysyx_25030085_core_seq.sv
// Directed bench for ysyx_25030085_core_seq: per-instruction cycle-schedule model plus a
// negedge compare process, with a few literal pins on the model.
module tb_ysyx_25030085_core_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          TB_TO  = 4;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req, lsu_req, rf_we, halt, err;
  logic [31:0] ifu_addr, inst, pc, halt_code;
  logic [63:0] instret;
  logic        ifu_ack = 1'b0, lsu_ack = 1'b0;
  logic        is_mem = 1'b0, is_store = 1'b0, rf_we_dec = 1'b0;
  logic [31:0] ifu_rdata = '0, next_pc = '0, halt_ret = 32'hdead_beef;

  ysyx_25030085_core_seq #(.RESET_PC(RST_PC), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n), .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ack(ifu_ack),
    .ifu_rdata(ifu_rdata), .inst(inst), .is_mem(is_mem), .is_store(is_store),
    .rf_we_dec(rf_we_dec), .lsu_req(lsu_req), .lsu_ack(lsu_ack), .next_pc(next_pc),
    .rf_we(rf_we), .pc(pc), .halt_ret(halt_ret), .halt(halt), .halt_code(halt_code),
    .err(err), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;
  int rfw_cnt = 0, lsu_cnt = 0;
  bit chk_en = 1'b0;

  // Architectural model state and the per-cycle expectations derived from it
  logic [31:0] m_pc, m_inst, m_halt_code;
  logic [63:0] m_instret;
  logic        e_ifu_req, e_lsu_req, e_rf_we, e_halt, e_err;
  logic [31:0] e_pc, e_inst, e_halt_code;
  logic [63:0] e_instret;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ifu_req", ifu_req, e_ifu_req);
      chk("lsu_req", lsu_req, e_lsu_req);
      chk("rf_we", rf_we, e_rf_we);
      chk("halt", halt, e_halt);
      chk("err", err, e_err);
      chk("pc", pc, e_pc);
      chk("ifu_addr", ifu_addr, e_pc);
      chk("inst", inst, e_inst);
      chk("halt_code", halt_code, e_halt_code);
      chk("instret", instret, e_instret);
      if (rf_we) rfw_cnt++;
      if (lsu_req) lsu_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp;
    e_ifu_req = 1'b0; e_lsu_req = 1'b0; e_rf_we = 1'b0; e_halt = 1'b0; e_err = 1'b0;
    e_pc = m_pc; e_inst = m_inst; e_halt_code = m_halt_code; e_instret = m_instret;
  endtask

  // Leaves the bench one cycle into FETCH, right after the BOOT cycle.
  task automatic do_reset;
    chk_en = 1'b0;
    rst_n = 1'b0; ifu_ack = 1'b0; lsu_ack = 1'b0;
    m_pc = RST_PC; m_inst = '0; m_instret = '0; m_halt_code = '0;
    tick;
    set_idle_exp; chk_en = 1'b1;
    tick;
    rst_n = 1'b1;
    set_idle_exp;
    tick;
  endtask

  // Runs one instruction from FETCH entry; fw/mw are ack wait cycles, noise raises the
  // acks outside their handshake states.
  task automatic run_insn(input logic [31:0] word, input bit mem, input bit st, input bit we,
                          input int fw, input int mw, input logic [31:0] npc, input bit noise,
                          output int cyc);
    cyc = 0;
    is_mem = mem; is_store = st; rf_we_dec = we; next_pc = npc; ifu_rdata = word;
    for (int i = 0; i <= fw; i++) begin
      set_idle_exp; e_ifu_req = 1'b1;
      ifu_ack = (i == fw); lsu_ack = noise;
      tick; cyc++;
    end
    m_inst = word;
    ifu_ack = noise;
    set_idle_exp;
    tick; cyc++;
    if (word == EBREAK) begin
      m_instret = m_instret + 64'd1;
      m_halt_code = halt_ret;
      ifu_ack = 1'b0; lsu_ack = 1'b0;
      return;
    end
    set_idle_exp;
    tick; cyc++;
    if (mem) begin
      for (int i = 0; i <= mw; i++) begin
        set_idle_exp; e_lsu_req = 1'b1;
        lsu_ack = (i == mw); ifu_ack = noise;
        tick; cyc++;
      end
    end
    lsu_ack = noise;
    set_idle_exp; e_rf_we = we && !st;
    tick; cyc++;
    m_pc = npc;
    m_instret = m_instret + 64'd1;
    ifu_ack = 1'b0; lsu_ack = 1'b0;
  endtask

  int cyc;

  initial begin
    do_reset;
    chk("boot_ifu_addr", ifu_addr, 32'h8000_0000);

    // ADDI, immediate acks
    rfw_cnt = 0;
    run_insn(32'h0010_0093, 1'b0, 1'b0, 1'b1, 0, 0, 32'h8000_0004, 1'b0, cyc);
    chk("addi_latency", cyc, 4);
    chk("addi_rfw_pulses", rfw_cnt, 1);
    chk("addi_pc", pc, 32'h8000_0004);
    chk("addi_instret", instret, 64'd1);

    // Store with LSU ack delayed 3 cycles
    rfw_cnt = 0; lsu_cnt = 0;
    run_insn(32'h0020_a023, 1'b1, 1'b1, 1'b1, 0, 3, 32'h8000_0008, 1'b0, cyc);
    chk("store_latency", cyc, 8);
    chk("store_lsu_cycles", lsu_cnt, 4);
    chk("store_rfw_pulses", rfw_cnt, 0);

    // ALU with fetch waits, stray acks, unaligned next_pc
    run_insn(32'h0020_8133, 1'b0, 1'b0, 1'b1, 2, 0, 32'h1234_5677, 1'b1, cyc);
    chk("alu_wait_latency", cyc, 6);
    // Load with waits and stray acks
    run_insn(32'h0000_a183, 1'b1, 1'b0, 1'b1, 1, 1, 32'h8000_0010, 1'b1, cyc);
    chk("load_latency", cyc, 7);
    // Ack arriving in the last tolerated wait cycle
    run_insn(32'h0000_0063, 1'b0, 1'b0, 1'b0, TB_TO, 0, 32'h8000_0020, 1'b0, cyc);
    chk("late_ack_latency", cyc, TB_TO + 4);
    chk("instret_5", instret, 64'd5);

`ifdef YSYX_25030085_SEQ_TIMEOUT_EN
    ifu_ack = 1'b0;
    for (int i = 0; i <= TB_TO; i++) begin
      set_idle_exp; e_ifu_req = 1'b1;
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      set_idle_exp; e_err = 1'b1; ifu_ack = 1'b1;
      tick;
    end
    chk("timeout_err", err, 1'b1);
`else
    run_insn(32'h0000_0013, 1'b0, 1'b0, 1'b1, 40, 0, 32'h8000_0024, 1'b0, cyc);
    chk("no_timeout_err", err, 1'b0);
`endif

    // Reset during MEM
    do_reset;
    run_insn(32'h0010_0093, 1'b0, 1'b0, 1'b1, 0, 0, 32'h8000_0004, 1'b0, cyc);
    is_mem = 1'b1; is_store = 1'b0; ifu_rdata = 32'h0000_a183; next_pc = 32'h8000_0008;
    set_idle_exp; e_ifu_req = 1'b1; ifu_ack = 1'b1;
    tick;
    m_inst = 32'h0000_a183; ifu_ack = 1'b0;
    set_idle_exp; tick;
    set_idle_exp; tick;
    set_idle_exp; e_lsu_req = 1'b1; lsu_ack = 1'b0;
    #6;
    rst_n = 1'b0;
    #1;
    chk("rst_lsu_req", lsu_req, 1'b0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_instret", instret, 64'd0);
    chk("rst_ifu_req", ifu_req, 1'b0);
    do_reset;

    // ebreak right after reset
    halt_ret = 32'h0000_002A;
    run_insn(EBREAK, 1'b0, 1'b0, 1'b1, 0, 0, 32'h8000_0004, 1'b0, cyc);
    chk("ebreak_latency", cyc, 2);
    for (int i = 0; i < 4; i++) begin
      set_idle_exp; e_halt = 1'b1; ifu_ack = 1'b1; lsu_ack = 1'b1;
      tick;
    end
    chk("ebreak_halt", halt, 1'b1);
    chk("ebreak_code", halt_code, 32'h0000_002A);
    chk("ebreak_instret", instret, 64'd1);
    chk("ebreak_no_fetch", ifu_req, 1'b0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_25030085_core_seq.md
# ysyx_25030085_core_seq

Multi-cycle instruction sequencer for the NPC core. Steps each instruction through fetch, decode, execute, optional memory access and writeback, driving the fetch and load/store handshakes and gating the combinational decoder's register-write strobe. Owns the architectural PC and the retired-instruction counter. Detects `ebreak` to halt the simulation cleanly.

## Interface
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset.
- `TIMEOUT`, 255, max wait cycles on a fetch/LSU handshake before error (range 1..1023).

- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ifu_req`  out  1  fetch request; high throughout FETCH.
- `ifu_addr`  out  32  fetch address; equals `pc`.
- `ifu_ack`  in  1  fetch data valid this cycle.
- `ifu_rdata`  in  32  fetched instruction.
- `inst`  out  32  instruction register, feeds decoder.
- `is_mem`  in  1  decoder: current `inst` is load/store.
- `is_store`  in  1  decoder: current `inst` is store.
- `rf_we_dec`  in  1  decoder RegWrite.
- `lsu_req`  out  1  LSU request; high throughout MEM.
- `lsu_ack`  in  1  LSU access complete.
- `next_pc`  in  32  datapath next-PC.
- `rf_we`  out  1  register-file write strobe.
- `pc`  out  32  architectural PC.
- `halt_ret`  in  32  current a0 value.
- `halt`  out  1  ebreak retired; sticky.
- `halt_code`  out  32  a0 captured at ebreak.
- `err`  out  1  handshake timeout; sticky.
- `instret`  out  64  retired-instruction count.

## Operation
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR. Outputs are Moore-decoded from state except `rf_we`.
- BOOT: one cycle after reset release, then FETCH.
- FETCH: `ifu_req`=1. On `ifu_ack`: `inst`<=`ifu_rdata`, go DECODE.
- DECODE: if `inst`==32'h0010_0073, `halt_code`<=`halt_ret`, `instret`+=1, go HALT. Otherwise go EXEC.
- EXEC: go MEM if `is_mem`, else WB.
- MEM: `lsu_req`=1. On `lsu_ack` go WB.
- WB: `rf_we`=`rf_we_dec` & ~`is_store` for exactly this cycle. `pc`<=`next_pc`. `instret`+=1. Go FETCH.
- HALT and ERR are absorbing until reset. `halt`=1 in HALT; `err`=1 in ERR. In both, all requests and `rf_we` are 0.
- Acks arriving outside FETCH/MEM are ignored. An ack is accepted on the first cycle its request is high.
- `pc` and `instret` wrap modulo 2^32 and 2^64 respectively. `next_pc` is used unmodified, with no alignment check.

## Timing
- Reset values: state BOOT, `pc`=`RESET_PC`, `inst`=0, `halt_code`=0, `instret`=0. All request/strobe/flag outputs are 0.
- Reset is asynchronous at any state, including mid-handshake. An outstanding request drops in the same cycle `rst_n` falls.
- Minimum latency with same-cycle acks:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - ebreak: 2 cycles from FETCH entry to `halt`=1.
- Each wait cycle without ack adds one cycle.
- `inst` is stable from DECODE through WB. The decoder inputs are sampled only in EXEC (`is_mem`) and WB (`rf_we_dec`, `is_store`).

## Configuration
- `YSYX_25030085_SEQ_TIMEOUT_EN` defined:
  - A 10-bit wait counter clears on entry to FETCH/MEM and increments each cycle without ack.
  - Entering a cycle where the counter equals `TIMEOUT` with no ack moves to ERR.
  - An ack in that same cycle wins.
- Not defined: no counter, handshakes wait indefinitely, `err` is tied 0, and the ERR state is unreachable.

## Test plan
- Reset then ADDI (32'h0010_0093, `rf_we_dec`=1) with immediate acks and `next_pc`=32'h8000_0004:
  - `ifu_addr`=32'h8000_0000.
  - `rf_we` is a single-cycle pulse in cycle 4.
  - `pc`=32'h8000_0004 and `instret`=1 afterwards.
- Store with `is_mem`=`is_store`=1, `rf_we_dec`=1, and `lsu_ack` delayed 3 cycles:
  - `lsu_req` is high for 4 cycles.
  - `rf_we` stays 0.
  - Total latency is 8 cycles.
- ebreak with `halt_ret`=32'h0000_002A:
  - `halt`=1 and `halt_code`=32'h2A.
  - `ifu_req` stays 0 thereafter.
  - `instret`=1.
- With the macro on and `TIMEOUT`=4, `ifu_ack` held 0: `err`=1 after exactly 5 FETCH cycles. Repeat with ack in that 5th cycle: no error, DECODE entered.
- Drop `rst_n` during MEM with `lsu_req` high: `lsu_req`=0 in the same cycle, `pc`=`RESET_PC`, `instret`=0, and BOOT then FETCH follow after release.
